mem_arbiter: RTL and testbench

- Shares the single-port SoC memory between the core's instruction-fetch port and its load/store port.
- Sits between the rv32 core and the memory block; it owns the memory's address, rd, wr and write-data lines.
- Serialises requests and allows one outstanding read.
- Returns read data to the requester that issued the read.

---
 rtl/rv32_mem_pkg.sv | 18 +
 rtl/rr_arb2.sv | 26 ++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared types for the rv32 memory arbiter: bus width defaults, requester
// identity and arbiter state encodings.
package rv32_mem_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way pick. Bit 0 is the fetch side, bit 1 the data side;
// on a tie the requester that did not win last time goes first when rr_en=1.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_win,
    input  logic       rr_en,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11: begin
                if (rr_en) begin
                    win = last_win ? 2'b01 : 2'b10;
                end else begin
                    win = 2'b10;
                end
            end
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports,
// issuing at most one read at a time and routing its data back to the issuer.
module mem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int MEM_LAT = 1,
    parameter int RR      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] LAT_END = 3'(MEM_LAT);

    arb_state_t        state_reg;
    owner_t            owner_reg;
    owner_t            last_win_reg;
    logic [2:0]        lat_cnt_reg;
    logic [1:0]        req;
    logic [1:0]        win;
    logic [1:0]        capture;
    logic              idle;
    logic              rd_done;
    logic              rvalid_reg [2];
    logic [DATA_W-1:0] rdata_reg  [2];

    // Grants are suppressed while reset is high so nothing reaches memory
    // in a cycle whose state update is about to be discarded.
    assign idle = (state_reg == ST_IDLE) && !reset;
    assign req  = idle ? {d_req, if_req} : 2'b00;

    rr_arb2 u_arb (
        .req      (req),
        .last_win (last_win_reg == OWN_D),
        .rr_en    (RR != 0),
        .win      (win)
    );

    assign if_gnt    = win[0];
    assign d_gnt     = win[1];
    assign mem_rd    = win[0] | (win[1] & ~d_we);
    assign mem_wr    = win[1] & d_we;
    assign mem_addr  = win[1] ? d_addr : (win[0] ? if_addr : '0);
    assign mem_wdata = mem_wr ? d_wdata : '0;
    assign rd_done   = (state_reg == ST_RD_WAIT) && (lat_cnt_reg == LAT_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= OWN_IF;
            last_win_reg <= OWN_D;
            lat_cnt_reg  <= 3'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win != 2'b00) begin
                        last_win_reg <= win[1] ? OWN_D : OWN_IF;
                    end
                    // Writes complete in the issue cycle; only reads wait.
                    if (mem_rd) begin
                        owner_reg   <= win[1] ? OWN_D : OWN_IF;
                        lat_cnt_reg <= 3'd1;
                        state_reg   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    lat_cnt_reg <= lat_cnt_reg + 3'd1;
                    if (rd_done) begin
                        lat_cnt_reg <= 3'd0;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Per-port return path: index 0 = fetch, index 1 = data.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign capture[gi] = rd_done && ((owner_reg == OWN_D) == (gi != 0));

            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else begin
                    rvalid_reg[gi] <= capture[gi];
                    if (capture[gi]) begin
                        rdata_reg[gi] <= mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign if_rvalid = rvalid_reg[0];
    assign if_rdata  = rdata_reg[0];
    assign d_rvalid  = rvalid_reg[1];
    assign d_rdata   = rdata_reg[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances cover RR=1/MEM_LAT=1,
// RR=0/MEM_LAT=1 and RR=1/MEM_LAT=3, each with its own memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req    [3];
    logic [31:0] if_addr   [3];
    logic        if_gnt    [3];
    logic        if_rvalid [3];
    logic [31:0] if_rdata  [3];
    logic        d_req     [3];
    logic        d_we      [3];
    logic [31:0] d_addr    [3];
    logic [31:0] d_wdata   [3];
    logic        d_gnt     [3];
    logic        d_rvalid  [3];
    logic [31:0] d_rdata   [3];
    logic [31:0] mem_addr  [3];
    logic        mem_rd    [3];
    logic        mem_wr    [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents after reset: word index i holds 0x13 + (i << 8).
    function automatic logic [31:0] exp_mem(input logic [31:0] a);
        return 32'h13 + {16'h0, a[9:2], 8'h0};
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int LAT = (gi == 2) ? 3 : 1;
            localparam int RRP = (gi == 1) ? 0 : 1;

            logic [31:0] mem  [256];
            logic [31:0] pipe [LAT];

            always @(posedge clk) begin
                if (reset) begin
                    for (int a = 0; a < 256; a++) begin
                        mem[a] <= 32'h13 + {16'h0, 8'(a), 8'h0};
                    end
                end else if (mem_wr[gi]) begin
                    mem[mem_addr[gi][9:2]] <= mem_wdata[gi];
                end
                pipe[0] <= mem[mem_addr[gi][9:2]];
                for (int s = 1; s < LAT; s++) begin
                    pipe[s] <= pipe[s-1];
                end
            end
            assign mem_rdata[gi] = pipe[LAT-1];

            mem_arbiter #(
                .ADDR_W  (32),
                .DATA_W  (32),
                .MEM_LAT (LAT),
                .RR      (RRP)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .if_req    (if_req[gi]),
                .if_addr   (if_addr[gi]),
                .if_gnt    (if_gnt[gi]),
                .if_rvalid (if_rvalid[gi]),
                .if_rdata  (if_rdata[gi]),
                .d_req     (d_req[gi]),
                .d_we      (d_we[gi]),
                .d_addr    (d_addr[gi]),
                .d_wdata   (d_wdata[gi]),
                .d_gnt     (d_gnt[gi]),
                .d_rvalid  (d_rvalid[gi]),
                .d_rdata   (d_rdata[gi]),
                .mem_addr  (mem_addr[gi]),
                .mem_rd    (mem_rd[gi]),
                .mem_wr    (mem_wr[gi]),
                .mem_wdata (mem_wdata[gi]),
                .mem_rdata (mem_rdata[gi])
            );
        end
    endgenerate

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            if_req[k]  = 1'b0;
            if_addr[k] = 32'h0;
            d_req[k]   = 1'b0;
            d_we[k]    = 1'b0;
            d_addr[k]  = 32'h0;
            d_wdata[k] = 32'h0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], mem_rd[k], mem_wr[k]} !== 6'b0) begin
                    failures++;
                    $display("FAIL reset_ctrl inst=%0d phase=%0d got=%b exp=000000", k, r,
                             {if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], mem_rd[k], mem_wr[k]});
                end
                checks++;
                if ({if_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]} !== 128'h0) begin
                    failures++;
                    $display("FAIL reset_data inst=%0d phase=%0d if_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h exp=0",
                             k, r, if_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]);
                end
            end
            next_cycle();
            reset = 1'b0;
        end
        $display("txn reset: outputs idle during and after reset");
    endtask

    task automatic test_fetch();
        do_reset();
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h0000_0000;
        @(negedge clk);
        checks++;
        if ({if_gnt[0], mem_rd[0], mem_addr[0]} !== {1'b1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL fetch_issue got gnt=%b rd=%b addr=%h exp gnt=1 rd=1 addr=0",
                     if_gnt[0], mem_rd[0], mem_addr[0]);
        end
        next_cycle();
        if_req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_gnt[0], if_rvalid[0], mem_rd[0]} !== 3'b000) begin
            failures++;
            $display("FAIL fetch_wait got gnt=%b rvalid=%b rd=%b exp 000", if_gnt[0], if_rvalid[0], mem_rd[0]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({if_rvalid[0], if_rdata[0], d_rvalid[0]} !== {1'b1, 32'h0000_0013, 1'b0}) begin
            failures++;
            $display("FAIL fetch_return got rvalid=%b rdata=%h d_rvalid=%b exp 1/00000013/0",
                     if_rvalid[0], if_rdata[0], d_rvalid[0]);
        end
        $display("txn fetch: addr=00000000 rdata=%h", if_rdata[0]);
        next_cycle();
    endtask

    task automatic test_rr_alternate();
        logic [31:0] pend_if;
        logic [31:0] pend_d;
        int          phase;
        pend_if = 32'h0;
        pend_d  = 32'h0;
        do_reset();
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h100;
        d_req[0]   = 1'b1;
        d_we[0]    = 1'b0;
        d_addr[0]  = 32'h200;
        for (int c = 0; c < 8; c++) begin
            phase = c % 4;
            @(negedge clk);
            checks++;
            if ({if_gnt[0], d_gnt[0]} !== {phase == 0, phase == 2}) begin
                failures++;
                $display("FAIL rr_grant cycle=%0d got if_gnt=%b d_gnt=%b exp if_gnt=%b d_gnt=%b",
                         c, if_gnt[0], d_gnt[0], phase == 0, phase == 2);
            end
            checks++;
            if ({if_rvalid[0], d_rvalid[0]} !== {phase == 2, (phase == 0) && (c > 0)}) begin
                failures++;
                $display("FAIL rr_rvalid cycle=%0d got if=%b d=%b exp if=%b d=%b",
                         c, if_rvalid[0], d_rvalid[0], phase == 2, (phase == 0) && (c > 0));
            end
            if (phase == 2) begin
                checks++;
                if (if_rdata[0] !== pend_if) begin
                    failures++;
                    $display("FAIL rr_if_data cycle=%0d got=%h exp=%h", c, if_rdata[0], pend_if);
                end
            end
            if (phase == 0 && c > 0) begin
                checks++;
                if (d_rdata[0] !== pend_d) begin
                    failures++;
                    $display("FAIL rr_d_data cycle=%0d got=%h exp=%h", c, d_rdata[0], pend_d);
                end
            end
            if (phase == 0) pend_if = exp_mem(if_addr[0]);
            if (phase == 2) pend_d  = exp_mem(d_addr[0]);
            $display("txn rr cycle=%0d if_gnt=%b d_gnt=%b if_rvalid=%b d_rvalid=%b",
                     c, if_gnt[0], d_gnt[0], if_rvalid[0], d_rvalid[0]);
            next_cycle();
            if (phase == 0) if_addr[0] = if_addr[0] + 32'h4;
            if (phase == 2) d_addr[0]  = d_addr[0] + 32'h4;
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back_writes();
        do_reset();
        d_req[0]   = 1'b1;
        d_we[0]    = 1'b1;
        d_addr[0]  = 32'h40;
        d_wdata[0] = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({d_gnt[0], mem_wr[0], mem_rd[0], d_rvalid[0]} !== 4'b1100) begin
                failures++;
                $display("FAIL wr_ctrl beat=%0d got gnt=%b wr=%b rd=%b rvalid=%b exp 1100",
                         i, d_gnt[0], mem_wr[0], mem_rd[0], d_rvalid[0]);
            end
            checks++;
            if ({mem_addr[0], mem_wdata[0]} !== {32'h40 + 32'(4 * i), 32'hDEAD_BEEF}) begin
                failures++;
                $display("FAIL wr_bus beat=%0d got addr=%h wdata=%h exp addr=%h wdata=deadbeef",
                         i, mem_addr[0], mem_wdata[0], 32'h40 + 32'(4 * i));
            end
            $display("txn write addr=%h data=%h", mem_addr[0], mem_wdata[0]);
            next_cycle();
            d_addr[0] = d_addr[0] + 32'h4;
        end
        d_we[0]    = 1'b0;
        d_addr[0]  = 32'h40;
        d_wdata[0] = 32'h0;
        @(negedge clk);
        checks++;
        if ({d_gnt[0], mem_rd[0], mem_wr[0]} !== 3'b110) begin
            failures++;
            $display("FAIL wr_readback_issue got gnt=%b rd=%b wr=%b exp 110", d_gnt[0], mem_rd[0], mem_wr[0]);
        end
        next_cycle();
        d_req[0] = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({d_rvalid[0], d_rdata[0]} !== {1'b1, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL wr_readback got rvalid=%b rdata=%h exp 1/deadbeef", d_rvalid[0], d_rdata[0]);
        end
        $display("txn read addr=00000040 data=%h", d_rdata[0]);
        next_cycle();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        if_req[1]  = 1'b1;
        if_addr[1] = 32'h10;
        d_req[1]   = 1'b1;
        d_addr[1]  = 32'h20;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({if_gnt[1], d_gnt[1]} !== {1'b0, (c % 2) == 0}) begin
                failures++;
                $display("FAIL fixed_grant cycle=%0d got if_gnt=%b d_gnt=%b exp if_gnt=0 d_gnt=%b",
                         c, if_gnt[1], d_gnt[1], (c % 2) == 0);
            end
            next_cycle();
        end
        d_req[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_gnt[1], d_rvalid[1], d_rdata[1]} !== {1'b1, 1'b1, exp_mem(32'h20)}) begin
            failures++;
            $display("FAIL fixed_release got if_gnt=%b d_rvalid=%b d_rdata=%h exp 1/1/%h",
                     if_gnt[1], d_rvalid[1], d_rdata[1], exp_mem(32'h20));
        end
        $display("txn fixed: if granted after d_req dropped, if_gnt=%b", if_gnt[1]);
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_latency3();
        do_reset();
        d_req[2]  = 1'b1;
        d_addr[2] = 32'h80;
        @(negedge clk);
        checks++;
        if (d_gnt[2] !== 1'b1) begin
            failures++;
            $display("FAIL lat3_issue got d_gnt=%b exp 1", d_gnt[2]);
        end
        next_cycle();
        d_req[2]   = 1'b0;
        if_req[2]  = 1'b1;
        if_addr[2] = 32'h0C;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({if_gnt[2], d_gnt[2], d_rvalid[2], mem_rd[2]} !== 4'b0000) begin
                failures++;
                $display("FAIL lat3_wait cycle=%0d got if_gnt=%b d_gnt=%b d_rvalid=%b rd=%b exp 0000",
                         c, if_gnt[2], d_gnt[2], d_rvalid[2], mem_rd[2]);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if ({d_rvalid[2], d_rdata[2], if_gnt[2]} !== {1'b1, exp_mem(32'h80), 1'b1}) begin
            failures++;
            $display("FAIL lat3_return got d_rvalid=%b d_rdata=%h if_gnt=%b exp 1/%h/1",
                     d_rvalid[2], d_rdata[2], if_gnt[2], exp_mem(32'h80));
        end
        $display("txn lat3 d read addr=00000080 data=%h", d_rdata[2]);
        next_cycle();
        if_req[2] = 1'b0;
        for (int c = 5; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (if_rvalid[2] !== 1'b0) begin
                failures++;
                $display("FAIL lat3_if_early cycle=%0d got if_rvalid=%b exp 0", c, if_rvalid[2]);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if ({if_rvalid[2], if_rdata[2]} !== {1'b1, exp_mem(32'h0C)}) begin
            failures++;
            $display("FAIL lat3_if_return got rvalid=%b rdata=%h exp 1/%h", if_rvalid[2], if_rdata[2], exp_mem(32'h0C));
        end
        $display("txn lat3 if read addr=0000000c data=%h", if_rdata[2]);
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h10;
        @(negedge clk);
        checks++;
        if (if_gnt[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrst_issue got if_gnt=%b exp 1", if_gnt[0]);
        end
        next_cycle();
        if_req[0] = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        checks++;
        if ({if_gnt[0], d_gnt[0], mem_rd[0], if_rvalid[0]} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_during got if_gnt=%b d_gnt=%b rd=%b if_rvalid=%b exp 0000",
                     if_gnt[0], d_gnt[0], mem_rd[0], if_rvalid[0]);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_rvalid[0], d_rvalid[0], mem_rd[0], mem_wr[0]} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_no_rvalid got if_rvalid=%b d_rvalid=%b rd=%b wr=%b exp 0000",
                     if_rvalid[0], d_rvalid[0], mem_rd[0], mem_wr[0]);
        end
        checks++;
        if ({if_rdata[0], d_rdata[0], mem_addr[0]} !== 96'h0) begin
            failures++;
            $display("FAIL midrst_data got if_rdata=%h d_rdata=%h mem_addr=%h exp 0",
                     if_rdata[0], d_rdata[0], mem_addr[0]);
        end
        next_cycle();
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h14;
        d_req[0]   = 1'b1;
        d_addr[0]  = 32'h24;
        @(negedge clk);
        checks++;
        if ({if_gnt[0], d_gnt[0]} !== 2'b10) begin
            failures++;
            $display("FAIL midrst_tie got if_gnt=%b d_gnt=%b exp if_gnt=1 d_gnt=0", if_gnt[0], d_gnt[0]);
        end
        $display("txn reset mid-read: tie after reset went to if_gnt=%b", if_gnt[0]);
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch();
        test_rr_alternate();
        test_back_to_back_writes();
        test_fixed_priority();
        test_latency3();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
